// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control chain: depth limit, counter
// type and the helper that sizes the flush-stage index.
package pipe_pkg;

   localparam int PIPE_MAX_STAGES = 16;
   localparam int PIPE_CNT_W      = 32;

   typedef logic [PIPE_CNT_W-1:0] pipe_cnt_t;

   // Width needed to express any value 0..n, so flush_stage can name
   // "every stage" (n) as well as each individual boundary.
   function automatic int stage_idx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: valid bit plus payload. Kill clears valid and
// wins over hold. Hold freezes both valid and payload. Otherwise the stage
// takes the incoming valid, and loads the payload only for a real
// transfer, so a bubble keeps its stale data.
module pipe_stage_reg #(
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              kill_i,
   input  logic              hold_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next-state selection with priority kill > hold > advance.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (kill_i) begin
         valid_d = 1'b0;
      end else if (!hold_i) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   // State register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// N-stage in-order pipeline register chain with per-stage hold, bubble
// collapse and age-ordered flush. Stage 0 is youngest, STAGES-1 oldest.
// Optional performance counters are built when PIPE_PERF_EN is defined;
// otherwise perf_retire/perf_bubble/perf_flush are tied to zero.
module pipe_ctrl_chain
   import pipe_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int DATA_W = 96,
   parameter int CNT_W  = 32,
   parameter int SW     = stage_idx_w(STAGES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   input  logic [STAGES-1:0]        stage_hold,
   input  logic [STAGES*DATA_W-1:0] stage_nxt_data,
   input  logic                     flush_valid,
   input  logic [SW-1:0]            flush_stage,
   output logic [STAGES-1:0]        stage_valid,
   output logic [STAGES*DATA_W-1:0] stage_data,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         perf_retire,
   output logic [CNT_W-1:0]         perf_bubble,
   output logic [CNT_W-1:0]         perf_flush
);

   logic [STAGES-1:0]        kill;
   logic [STAGES-1:0]        stall;
   logic [STAGES-2:0]        xfer;
   logic [STAGES-1:0]        valid_d;
   logic [STAGES*DATA_W-1:0] data_d;
   logic                     unusedNxt;

   // The oldest stage has no successor, so its next-data slice is ignored.
   assign unusedNxt = ^stage_nxt_data[(STAGES-1)*DATA_W +: DATA_W];

   // Kill mask, stall chain (oldest to youngest) and per-stage load values.
   // A killed stage never stalls, so older held stages stay held while the
   // younger ones are discarded; an empty stage never stalls either, which
   // lets bubbles collapse under a hold further down the chain.
   always_comb begin
      kill    = '0;
      stall   = '0;
      xfer    = '0;
      valid_d = '0;
      data_d  = '0;
      for (int i = 0; i < STAGES; i++) begin
         kill[i] = flush_valid && (flush_stage > SW'(i));
      end
      stall[STAGES-1] = stage_valid[STAGES-1] & (stage_hold[STAGES-1] | ~out_ready)
                        & ~kill[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         stall[i] = stage_valid[i] & (stage_hold[i] | stall[i+1]) & ~kill[i];
      end
      for (int i = 0; i < STAGES - 1; i++) begin
         xfer[i] = stage_valid[i] & ~stall[i] & ~kill[i];
      end
      in_ready             = ~stall[0] & ~flush_valid;
      valid_d[0]           = in_valid & in_ready;
      data_d[0 +: DATA_W]  = in_data;
      for (int i = 1; i < STAGES; i++) begin
         valid_d[i]                 = xfer[i-1];
         data_d[i*DATA_W +: DATA_W] = stage_nxt_data[(i-1)*DATA_W +: DATA_W];
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      pipe_stage_reg #(
         .DATA_W (DATA_W)
      ) u_reg (
         .clk     (clk),
         .rst_n   (rst),
         .kill_i  (kill[g]),
         .hold_i  (stall[g]),
         .valid_i (valid_d[g]),
         .data_i  (data_d[g*DATA_W +: DATA_W]),
         .valid_o (stage_valid[g]),
         .data_o  (stage_data[g*DATA_W +: DATA_W])
      );
   end

   assign out_valid = stage_valid[STAGES-1] & ~stage_hold[STAGES-1] & ~kill[STAGES-1];
   assign out_data  = stage_data[(STAGES-1)*DATA_W +: DATA_W];

`ifdef PIPE_PERF_EN
   logic             retire;
   logic [CNT_W-1:0] retireCnt_q, bubbleCnt_q, flushCnt_q;

   assign retire = out_valid & out_ready;

   // Saturating event counters: retires, empty-oldest-stage cycles and
   // effective flush cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retireCnt_q <= '0;
         bubbleCnt_q <= '0;
         flushCnt_q  <= '0;
      end else begin
         if (retire && (retireCnt_q != '1)) begin
            retireCnt_q <= retireCnt_q + CNT_W'(1);
         end
         if (!stage_valid[STAGES-1] && (bubbleCnt_q != '1)) begin
            bubbleCnt_q <= bubbleCnt_q + CNT_W'(1);
         end
         if (flush_valid && (flush_stage != '0) && (flushCnt_q != '1)) begin
            flushCnt_q <= flushCnt_q + CNT_W'(1);
         end
      end
   end

   assign perf_retire = retireCnt_q;
   assign perf_bubble = bubbleCnt_q;
   assign perf_flush  = flushCnt_q;
`else
   assign perf_retire = '0;
   assign perf_bubble = '0;
   assign perf_flush  = '0;
`endif

endmodule
